// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
//   Shared types and constants for the bit_serializer block.
//   - state_t      : serializer FSM states (PARITY is only reachable when the
//                    SER_PARITY_EN macro is defined)
//   - DATA_W_DEF   : default parallel word width
package bit_serializer_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serializer_shift_reg.sv
// ser_shift_reg
//   Loadable MSB-first shift register. A load overrides a shift on the same
//   edge; shifting moves the word toward the MSB and fills with zeros.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-low reset (clears the register)
//   load_i  : load d_i into the register
//   shift_i : shift left by one bit
//   d_i     : parallel load word
//   msb_o   : current MSB (the bit being presented on the serial line)
module ser_shift_reg
  import bit_serializer_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] d_i,
  output logic         msb_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= d_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
//   Double-buffered parallel-to-serial converter, MSB first. One shift
//   register carries the frame on the line; one hold register buffers the
//   next word so back-to-back words stream without gaps.
//   Optional macro SER_PARITY_EN appends an even-parity bit to each frame.
// Handshake: a word transfers on a rising edge where in_valid and in_ready
//   are both 1; in_ready is registered and is low while the hold register
//   is full (and during reset).
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous active-low reset
//   in_data     : parallel word to serialize
//   in_valid    : in_data valid this cycle
//   in_ready    : block can accept a word this cycle
//   ser_out     : serial bit (0 whenever ser_valid is 0)
//   ser_valid   : ser_out carries a frame bit this cycle
//   busy        : shifter or hold register occupied
//   dbg_state_o : current FSM state (state_t encoding)
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic              in_ready_q;
  logic              ser_valid_q;
`ifdef SER_PARITY_EN
  logic              parity_q;
`endif

  logic              xfer;
  logic              frame_last;
  logic              load_en;
  logic [DATA_W-1:0] load_data;
  logic              shift_en;
  logic              hold_wr;
  logic              hold_full_d;
  logic              sr_msb;

  assign xfer = in_valid & in_ready_q;

  // The bit on the line this cycle is the last one of its frame.
`ifdef SER_PARITY_EN
  assign frame_last = (state_q == PARITY);
`else
  assign frame_last = (state_q == SHIFT) && (cnt_q == '0);
`endif

  // Shifter load source: a new word from IDLE, or at frame end the held
  // word (preferred) or a word arriving on the final bit.
  always_comb begin
    load_en   = 1'b0;
    load_data = '0;
    if (state_q == IDLE) begin
      load_en   = xfer;
      load_data = in_data;
    end else if (frame_last) begin
      if (hold_full_q) begin
        load_en   = 1'b1;
        load_data = hold_q;
      end else if (xfer) begin
        load_en   = 1'b1;
        load_data = in_data;
      end
    end
  end

  assign shift_en = (state_q == SHIFT) && !load_en;

  // Words arriving mid-frame park in the hold register.
  assign hold_wr = (state_q != IDLE) && !frame_last && xfer;

  always_comb begin
    hold_full_d = hold_full_q;
    if (frame_last && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (hold_wr) begin
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
      ser_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      hold_full_q <= hold_full_d;
      in_ready_q  <= ~hold_full_d;
      if (hold_wr) begin
        hold_q <= in_data;
      end
      if (frame_last) begin
        if (load_en) begin
          state_q <= SHIFT;
          cnt_q   <= CNT_TOP;
`ifdef SER_PARITY_EN
          parity_q <= ^load_data;
`endif
        end else begin
          state_q     <= IDLE;
          ser_valid_q <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (xfer) begin
              state_q     <= SHIFT;
              cnt_q       <= CNT_TOP;
              ser_valid_q <= 1'b1;
`ifdef SER_PARITY_EN
              parity_q    <= ^in_data;
`endif
            end
          end
          SHIFT: begin
            // Counter stops at zero; reaching zero is handled as frame end
            // (or entry to PARITY) rather than wrapping.
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end
`ifdef SER_PARITY_EN
            else begin
              state_q <= PARITY;
            end
`endif
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  ser_shift_reg #(
    .W(DATA_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_en),
    .shift_i (shift_en),
    .d_i     (load_data),
    .msb_o   (sr_msb)
  );

`ifdef SER_PARITY_EN
  assign ser_out = ser_valid_q & ((state_q == PARITY) ? parity_q : sr_msb);
`else
  assign ser_out = ser_valid_q & sr_msb;
`endif

  assign in_ready    = in_ready_q;
  assign ser_valid   = ser_valid_q;
  assign busy        = ser_valid_q | hold_full_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Directed and random stimulus for bit_serializer (DATA_W=8). The reference
//   model is a queue of bits still owed on the serial line: each accepted
//   word appends its frame, each clock pops the bit just shown. The hold
//   register is full exactly when more than one frame of bits is owed.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  bit_serializer #(.DATA_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Scoreboard
  logic exp_q[$];
  bit   armed;
  bit   last_acc;
  int   checks;
  int   errors;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".ser_valid"}, {7'd0, ser_valid}, {7'd0, n > 0});
    check({tag, ".ser_out"},   {7'd0, ser_out},   {7'd0, (n > 0) ? exp_q[0] : 1'b0});
    check({tag, ".in_ready"},  {7'd0, in_ready},  {7'd0, armed && (n <= FRAME)});
    check({tag, ".busy"},      {7'd0, busy},      {7'd0, n > 0});
    if (n == 0) begin
      check({tag, ".idle_state"}, {6'd0, dbg_state}, {6'd0, IDLE});
    end
  endtask

  // Reference model update for one rising edge.
  task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r);
    logic acc;
    logic [W-1:0] word;
    acc = 1'b0;
    if (!r) begin
      exp_q.delete();
      armed = 1'b0;
    end else begin
      acc = v && armed && (exp_q.size() <= FRAME);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) begin
        word = d;
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(word[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(^word);
`endif
      end
      armed = 1'b1;
    end
    last_acc = acc;
  endtask

  // Driver: apply inputs, clock once, sample on the falling edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input string tag);
    in_valid = v;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    model_edge(v, d, r);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    armed    = 1'b0;
    last_acc = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset held for three edges, then release.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, "reset");
    step(1'b0, 8'h00, 1'b1, "release");

    // Single word.
    step(1'b1, 8'hB0, 1'b1, "single_acc");
    for (int i = 0; i < FRAME + 2; i++) step(1'b0, 8'h00, 1'b1, "single");

    // Back-to-back words, then a third word held under backpressure.
    step(1'b1, 8'hB0, 1'b1, "b2b_first");
    step(1'b1, 8'h0B, 1'b1, "b2b_second");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'hFF, 1'b1, "backpressure");
      if (last_acc) break;
    end
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 8'h00, 1'b1, "drain1");

`ifdef SER_PARITY_EN
    step(1'b1, 8'hB4, 1'b1, "parity_b4");
    for (int i = 0; i < FRAME + 2; i++) step(1'b0, 8'h00, 1'b1, "parity_b4");
`endif

    // Mid-frame reset after three bits, with a word in the hold register.
    step(1'b1, 8'hB0, 1'b1, "mid_acc");
    step(1'b1, 8'h0B, 1'b1, "mid_hold");
    step(1'b0, 8'h00, 1'b1, "mid_bit3");
    step(1'b0, 8'h00, 1'b0, "mid_reset");
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 8'h00, 1'b1, "post_reset");

    // Continuous valid: the line must stay busy with no bubbles.
    for (int i = 0; i < 40; i++) step(1'b1, W'($urandom_range(0, 255)), 1'b1, "stream");
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 8'h00, 1'b1, "drain2");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), W'($urandom_range(0, 255)),
           ($urandom_range(0, 63) != 0), "random");
    end
    for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 8'h00, 1'b1, "drain3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
